i2s_tx_param: RTL
=================

# i2s_tx_param

Parameterised I2S/left-justified audio transmitter. It is the successor to the fixed 16-bit stereo speaker driver and sits between the audio sample source and the external stereo DAC. Sample width, slot width, bit-clock divider and framing mode are parameters. Samples enter through a valid/ready handshake with a one-frame holding register, and the block detects underrun and supports mute. All outputs are generated and registered in the single `clk` domain; nothing is clocked on `audio_bck`.

## Interface
- `SAMPLE_W`, 16: sample width in bits, 8..32, two's complement.
- `SLOT_W`, 16: bits per channel slot, SAMPLE_W..32.
- `CLK_DIV`, 4: `audio_bck` half-period in `clk` cycles, ≥1. The default gives 5 MHz from 40 MHz.
- `I2S_MODE`, 0: 0 = left-justified, 1 = Philips I2S (`audio_ws` leads the MSB by one bit).
- `LEFT_WS`, 1: `audio_ws` level during the left slot.
- `UNDERRUN_ZERO`, 0: 0 = repeat the last frame on underrun, 1 = send zeros.

Ports:
- `clk` in 1: system clock, 40 MHz.
- `rst_n` in 1: one clock; reset is synchronous and active-low.
- `s_left`, `s_right` in SAMPLE_W: sample pair.
- `s_valid` in 1: sample pair offered.
- `s_ready` out 1: holding register empty; a transfer occurs when `s_valid && s_ready`.
- `mute` in 1: sampled at frame load.
- `frame_start` out 1: 1-cycle pulse at frame load.
- `underrun` out 1: 1-cycle pulse when a frame loads with no pending sample.
- `audio_appsel` out 1: constant 1 (stereo).
- `audio_sysclk` out 1: equals `clk`.
- `audio_bck` out 1: bit clock.
- `audio_ws` out 1: word select.
- `audio_data` out 1: serial data, MSB first.

## Operation
Bit clock:
- `div_cnt` counts 0..CLK_DIV-1 and wraps.
- At wrap, `audio_bck` toggles.
- A fall event is a cycle with `div_cnt==CLK_DIV-1 && audio_bck==1`.

Frame counter:
- `bit_cnt` counts 0..2*SLOT_W-1 and advances only on a fall event.
- At a fall event with `bit_cnt==2*SLOT_W-1` it wraps to 0. This is the frame load.
- Slot: `bit_cnt < SLOT_W` is left, otherwise right.
- Position `p = bit_cnt mod SLOT_W`.

Data and word select:
- `audio_data` = `word[SAMPLE_W-1-p]` when `p < SAMPLE_W`, else 0.
- `word` is the active left or right register, selected by slot.
- `audio_ws` = `LEFT_WS` if `(bit_cnt+I2S_MODE) mod 2*SLOT_W < SLOT_W`, else `~LEFT_WS`.

Holding register:
- `pend_valid`, `pend_l`, `pend_r`.
- `s_ready = ~pend_valid`, driven combinationally from the register.
- An accepted transfer sets `pend_valid` and captures `s_left`/`s_right`.

Frame load, in priority order:
- `mute` = 1: active registers load 0. A pending pair is still consumed (`pend_valid` cleared); no underrun pulse.
- else `pend_valid` = 1: active registers load `pend_l`/`pend_r`; `pend_valid` is cleared.
- else: underrun pulses. Active registers hold their value (`UNDERRUN_ZERO`=0) or load 0 (`UNDERRUN_ZERO`=1).

Other rules:
- `frame_start` pulses on every frame load.
- A new transfer in the frame-load cycle is impossible while `pend_valid`=1, because `s_ready`=0. When `pend_valid`=0 and an underrun occurs, a transfer in that same cycle is captured into the holding register. The active registers still take the underrun behaviour; the captured sample is used at the next frame load.

## Timing
Reset values:
- `audio_bck`, `audio_data`, `div_cnt`: 0.
- Active registers, `pend_valid`, `frame_start`, `underrun`: 0.
- `bit_cnt` = 2*SLOT_W-1.
- `audio_ws` = `~LEFT_WS` if `I2S_MODE`=0, else `LEFT_WS`.
- `s_ready` = 1.

Reset asserted mid-frame takes effect at the next `clk` edge and restores all of the above. A pending sample is discarded.

Cycle timing:
- First `audio_bck` rise is 1×CLK_DIV cycles after reset release. The first fall event and first frame load come at 2×CLK_DIV cycles.
- `audio_bck`, `audio_ws` and `audio_data` are registered and update on the same `clk` edge as the `audio_bck` fall. Data is stable at the `audio_bck` rise.
- Bit period is 2·CLK_DIV cycles; frame is 4·CLK_DIV·SLOT_W cycles. Defaults give 256 cycles, with `audio_ws` toggling every 128.
- Latency from accept to MSB on `audio_data` is at most one frame plus one bit.

## Test plan
- **Defaults, reset then release:**
  - Outputs are at their reset values and `audio_ws`=0 while `rst_n`=0.
  - `audio_bck` first rises 4 cycles after release; period is 8 cycles.
  - `frame_start` pulses at cycle 8 with `underrun` (no sample pending yet).
- **Defaults, one pair:** push L=16'hA55A, R=16'h0F0F before the second load.
  - Sampling `audio_data` on `audio_bck` rises gives A55A then 0F0F, MSB first.
  - `audio_ws`=1 for the 16 left bits.
  - The next frame repeats the pair and pulses `underrun`.
- **`I2S_MODE`=1:** `audio_ws` changes one bit (8 cycles) before each slot MSB, and the MSB lands on the first bit after the change.
- **`SAMPLE_W`=24, `SLOT_W`=32, L=24'h800001:**
  - Left slot is bits 1,0×22,1 followed by 8 zeros.
  - Frame is 512 cycles.
- **Backpressure:** push two pairs back to back.
  - `s_ready` drops after the first accept and stays 0 until the next `frame_start`.
  - The second pair transfers afterwards and plays in the following frame with no `underrun`.
- **`mute`=1 over one load with a pair pending:** that frame is all zeros, `pend_valid` clears and no `underrun` pulses. With `UNDERRUN_ZERO`=1 and a starved load, `audio_data` is zero.

Source files
------------

// File: rtl/i2s_tx_param.sv
// Parameterised I2S / left-justified stereo transmitter with a one-frame holding
// register, underrun detection and mute. Everything runs in the clk domain.
module i2s_tx_param #(
  parameter int unsigned SAMPLE_W      = 16,
  parameter int unsigned SLOT_W        = 16,
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned I2S_MODE      = 0,
  parameter int unsigned LEFT_WS       = 1,
  parameter int unsigned UNDERRUN_ZERO = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                mute,
  output logic                frame_start,
  output logic                underrun,
  output logic                audio_appsel,
  output logic                audio_sysclk,
  output logic                audio_bck,
  output logic                audio_ws,
  output logic                audio_data
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_W;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
  localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_BITS   = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] SAMPLE_BITS = BIT_W'(SAMPLE_W);
  localparam logic [BIT_W-1:0] MSB_POS     = BIT_W'(SAMPLE_W - 1);
  localparam logic             LEFT_LVL    = 1'(LEFT_WS);
  localparam logic             WS_RST      = (I2S_MODE != 0) ? LEFT_LVL : ~LEFT_LVL;

  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] act_l;
  logic [SAMPLE_W-1:0] act_r;
  logic [SAMPLE_W-1:0] pend_l;
  logic [SAMPLE_W-1:0] pend_r;
  logic                pend_valid;

  logic                div_wrap;
  logic                fall;
  logic                frame_load;
  logic                accept;
  logic [BIT_W-1:0]    bit_nxt;
  logic [SAMPLE_W-1:0] act_l_nxt;
  logic [SAMPLE_W-1:0] act_r_nxt;
  logic                underrun_nxt;
  logic                slot_right;
  logic [BIT_W-1:0]    pos;
  logic [SAMPLE_W-1:0] word;
  logic [SAMPLE_W-1:0] bit_mask;
  logic                data_nxt;
  logic                ws_left;
  logic                ws_nxt;

  assign audio_appsel = 1'b1;
  assign audio_sysclk = clk;
  assign s_ready      = ~pend_valid;

  assign div_wrap   = (div_cnt == DIV_LAST);
  assign fall       = div_wrap && audio_bck;
  assign frame_load = fall && (bit_cnt == LAST_BIT);
  assign accept     = s_valid && ~pend_valid;

  // Frame position after this edge; outputs are computed from it so they
  // change on the same clk edge as the bit clock falls.
  always_comb begin
    bit_nxt = bit_cnt;
    if (fall) begin
      bit_nxt = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
    end
  end

  // Active-register update at frame load: mute beats pending beats underrun.
  always_comb begin
    act_l_nxt    = act_l;
    act_r_nxt    = act_r;
    underrun_nxt = 1'b0;
    if (frame_load) begin
      if (mute) begin
        act_l_nxt = '0;
        act_r_nxt = '0;
      end else if (pend_valid) begin
        act_l_nxt = pend_l;
        act_r_nxt = pend_r;
      end else begin
        underrun_nxt = 1'b1;
        if (UNDERRUN_ZERO != 0) begin
          act_l_nxt = '0;
          act_r_nxt = '0;
        end
      end
    end
  end

  // Serial bit and word select for the upcoming bit position.
  always_comb begin
    slot_right = (bit_nxt >= SLOT_BITS);
    pos        = slot_right ? (bit_nxt - SLOT_BITS) : bit_nxt;
    word       = slot_right ? act_r_nxt : act_l_nxt;
    bit_mask   = SAMPLE_W'(1) << (MSB_POS - pos);
    data_nxt   = (pos < SAMPLE_BITS) ? |(word & bit_mask) : 1'b0;
    if (I2S_MODE != 0) begin
      ws_left = (bit_nxt == LAST_BIT) || (bit_nxt < (SLOT_BITS - BIT_W'(1)));
    end else begin
      ws_left = (bit_nxt < SLOT_BITS);
    end
    ws_nxt = ws_left ? LEFT_LVL : ~LEFT_LVL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      audio_bck   <= 1'b0;
      bit_cnt     <= LAST_BIT;
      audio_ws    <= WS_RST;
      audio_data  <= 1'b0;
      act_l       <= '0;
      act_r       <= '0;
      pend_l      <= '0;
      pend_r      <= '0;
      pend_valid  <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (div_wrap) begin
        div_cnt   <= '0;
        audio_bck <= ~audio_bck;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      bit_cnt     <= bit_nxt;
      act_l       <= act_l_nxt;
      act_r       <= act_r_nxt;
      frame_start <= frame_load;
      underrun    <= underrun_nxt;
      if (fall) begin
        audio_ws   <= ws_nxt;
        audio_data <= data_nxt;
      end
      // A transfer in the load cycle is only possible when nothing is pending,
      // so capture and consume never collide.
      if (accept) begin
        pend_l     <= s_left;
        pend_r     <= s_right;
        pend_valid <= 1'b1;
      end else if (frame_load) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule
